semaphore_arbiter: RTL and testbench

- Owns lock state for a bank of hardware semaphores shared by all PLC cores.
- Accepts per-core acquire/release requests and arbitrates simultaneous acquires of a free semaphore round-robin.
- Returns a one-cycle ACK with a GRANTED flag to each requester.
- Emits the per-semaphore, per-core write-enable vector consumed by the semaphore write controller.

---
 rtl/semaphore_arbiter.sv | 149 ++++++++++++++
 tb/tb_semaphore_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/semaphore_arbiter.sv
// Hardware semaphore bank: release-then-acquire resolution with round-robin acquire arbitration.
// Define SEMAPHORE_TIMEOUT_EN to add per-semaphore hold counters and forced release.
module semaphore_arbiter #(
  parameter int NumberOfSemaphores = 4,
  parameter int NumberOfCores      = 2,
  parameter int TimeoutCycles      = 1024,
  localparam int SW = (NumberOfSemaphores > 1) ? $clog2(NumberOfSemaphores) : 1,
  localparam int CW = (NumberOfCores > 1) ? $clog2(NumberOfCores) : 1
) (
  input  logic                                         SEMAPHOREARBITER_CLK,
  input  logic                                         SEMAPHOREARBITER_RST,
  input  logic [NumberOfCores-1:0]                     SEMAPHOREARBITER_REQ,
  input  logic [NumberOfCores-1:0]                     SEMAPHOREARBITER_OP,
  input  logic [NumberOfCores*SW-1:0]                  SEMAPHOREARBITER_ID,
  output logic [NumberOfCores-1:0]                     SEMAPHOREARBITER_ACK,
  output logic [NumberOfCores-1:0]                     SEMAPHOREARBITER_GRANTED,
  output logic [NumberOfSemaphores-1:0]                SEMAPHOREARBITER_LOCKED,
  output logic [NumberOfSemaphores*CW-1:0]             SEMAPHOREARBITER_OWNER,
  output logic [NumberOfSemaphores*NumberOfCores-1:0]  SEMAPHOREARBITER_WE,
  output logic [NumberOfSemaphores-1:0]                SEMAPHOREARBITER_TIMEOUT
);
  localparam int NS = NumberOfSemaphores;
  localparam int NC = NumberOfCores;

  logic [NC-1:0]    req_q, op_q, in_rng, rel_ok, acq_ok, acq_gnt;
  logic [NC*SW-1:0] id_q;
  logic [SW-1:0]    cid [NC];
  logic [NS-1:0]    locked, rel_hit, expire, free1, win_vld;
  logic [CW-1:0]    owner [NS];
  logic [CW-1:0]    rr [NS];
  logic [CW-1:0]    win [NS];

  // Requests are registered first; a reset on the following edge drops their ACK.
  always_ff @(posedge SEMAPHOREARBITER_CLK) begin
    if (SEMAPHOREARBITER_RST) begin
      req_q <= '0;
      op_q  <= '0;
      id_q  <= '0;
    end else begin
      req_q <= SEMAPHOREARBITER_REQ;
      op_q  <= SEMAPHOREARBITER_OP;
      id_q  <= SEMAPHOREARBITER_ID;
    end
  end

  for (genvar c = 0; c < NC; c++) begin : g_core
    assign cid[c]    = id_q[c*SW +: SW];
    assign in_rng[c] = ({1'b0, cid[c]} < (SW+1)'(NS));
  end

  always_comb begin
    rel_ok  = '0;
    acq_ok  = '0;
    rel_hit = '0;
    for (int c = 0; c < NC; c++) begin
      if (req_q[c] && in_rng[c]) begin
        if (op_q[c]) acq_ok[c] = 1'b1;
        else if (locked[cid[c]] && owner[cid[c]] == CW'(c)) begin
          rel_ok[c]         = 1'b1;
          rel_hit[cid[c]]   = 1'b1;
        end
      end
    end
  end

  // A semaphore is free for phase 2 if unlocked, just released, or just timed out.
  assign free1 = ~locked | rel_hit | expire;

  // Scan from the highest offset down so the core closest to RR wins.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      win_vld[s] = 1'b0;
      win[s]     = '0;
      for (int k = NC - 1; k >= 0; k--) begin
        if (acq_ok[CW'((int'(rr[s]) + k) % NC)] &&
            cid[CW'((int'(rr[s]) + k) % NC)] == SW'(s)) begin
          win_vld[s] = 1'b1;
          win[s]     = CW'((int'(rr[s]) + k) % NC);
        end
      end
    end
  end

  always_comb begin
    acq_gnt = '0;
    for (int c = 0; c < NC; c++)
      acq_gnt[c] = acq_ok[c] && (free1[cid[c]] ? (win[cid[c]] == CW'(c))
                                               : (owner[cid[c]] == CW'(c)));
  end

  always_ff @(posedge SEMAPHOREARBITER_CLK) begin
    if (SEMAPHOREARBITER_RST) begin
      SEMAPHOREARBITER_ACK     <= '0;
      SEMAPHOREARBITER_GRANTED <= '0;
      SEMAPHOREARBITER_WE      <= '0;
      locked                   <= '0;
      for (int s = 0; s < NS; s++) begin
        owner[s] <= '0;
        rr[s]    <= '0;
      end
    end else begin
      SEMAPHOREARBITER_ACK     <= req_q;
      SEMAPHOREARBITER_GRANTED <= rel_ok | acq_gnt;
      for (int s = 0; s < NS; s++) begin
        if (free1[s]) begin
          locked[s] <= win_vld[s];
          owner[s]  <= win_vld[s] ? win[s] : '0;
          if (win_vld[s])
            rr[s] <= (win[s] == CW'(NC - 1)) ? '0 : win[s] + CW'(1);
        end
        for (int c = 0; c < NC; c++)
          SEMAPHOREARBITER_WE[s*NC + c] <= free1[s] && win_vld[s] && (win[s] == CW'(c));
      end
    end
  end

  assign SEMAPHOREARBITER_LOCKED = locked;
  for (genvar s = 0; s < NS; s++) begin : g_own
    assign SEMAPHOREARBITER_OWNER[s*CW +: CW] = owner[s];
  end

`ifdef SEMAPHORE_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] hold [NS];

  // An owner release in the expiry cycle takes precedence over the forced release.
  always_comb begin
    for (int s = 0; s < NS; s++)
      expire[s] = locked[s] && (hold[s] == TW'(TimeoutCycles)) && !rel_hit[s];
  end

  always_ff @(posedge SEMAPHOREARBITER_CLK) begin
    if (SEMAPHOREARBITER_RST) begin
      SEMAPHOREARBITER_TIMEOUT <= '0;
      for (int s = 0; s < NS; s++) hold[s] <= '0;
    end else begin
      SEMAPHOREARBITER_TIMEOUT <= expire;
      for (int s = 0; s < NS; s++) begin
        if (free1[s])       hold[s] <= '0;
        else if (locked[s]) hold[s] <= hold[s] + TW'(1);
      end
    end
  end
`else
  assign expire                   = '0;
  assign SEMAPHOREARBITER_TIMEOUT = '0;
`endif

endmodule

// File: tb/tb_semaphore_arbiter.sv
// Self-checking bench: two arbiters (4 and 3 semaphores, 2 cores) share stimulus and
// are compared against a sequential lock-table model plus directed scenario checks.
module tb_semaphore_arbiter;
  localparam int NC = 2;
  localparam int TC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] req = '0, op = '0;
  logic [3:0] id = '0;

  logic [1:0] ack4, gnt4, ack3, gnt3;
  logic [3:0] lk4, ow4, to4;
  logic [7:0] we4;
  logic [2:0] lk3, ow3, to3;
  logic [5:0] we3;

  semaphore_arbiter #(.NumberOfSemaphores(4), .NumberOfCores(NC), .TimeoutCycles(TC)) u_dut4 (
    .SEMAPHOREARBITER_CLK(clk), .SEMAPHOREARBITER_RST(rst),
    .SEMAPHOREARBITER_REQ(req), .SEMAPHOREARBITER_OP(op), .SEMAPHOREARBITER_ID(id),
    .SEMAPHOREARBITER_ACK(ack4), .SEMAPHOREARBITER_GRANTED(gnt4),
    .SEMAPHOREARBITER_LOCKED(lk4), .SEMAPHOREARBITER_OWNER(ow4),
    .SEMAPHOREARBITER_WE(we4), .SEMAPHOREARBITER_TIMEOUT(to4));

  semaphore_arbiter #(.NumberOfSemaphores(3), .NumberOfCores(NC), .TimeoutCycles(TC)) u_dut3 (
    .SEMAPHOREARBITER_CLK(clk), .SEMAPHOREARBITER_RST(rst),
    .SEMAPHOREARBITER_REQ(req), .SEMAPHOREARBITER_OP(op), .SEMAPHOREARBITER_ID(id),
    .SEMAPHOREARBITER_ACK(ack3), .SEMAPHOREARBITER_GRANTED(gnt3),
    .SEMAPHOREARBITER_LOCKED(lk3), .SEMAPHOREARBITER_OWNER(ow3),
    .SEMAPHOREARBITER_WE(we3), .SEMAPHOREARBITER_TIMEOUT(to3));

  wire [23:0] obs4 = {ack4, gnt4, lk4, ow4, we4, to4};
  wire [18:0] obs3 = {ack3, gnt3, lk3, ow3, we3, to3};
  logic [23:0] exp4;
  logic [18:0] exp3;
  int n_vec = 0, n_bad = 0;

  // Lock table per instance: lock flag, owner, round-robin start, hold cycles.
  int lk [2][4], ow [2][4], rr [2][4], cnt [2][4];
  logic [1:0] p_req = '0, p_op = '0;
  logic [3:0] p_id = '0;
  logic [1:0] e_ack [2], e_gnt [2];
  logic [7:0] e_we [2];
  logic [3:0] e_to [2];

  task automatic model_reset(input int i);
    for (int s = 0; s < 4; s++) begin
      lk[i][s] = 0; ow[i][s] = 0; rr[i][s] = 0; cnt[i][s] = 0;
    end
    e_ack[i] = '0; e_gnt[i] = '0; e_we[i] = '0; e_to[i] = '0;
  endtask

  task automatic model_step(input int i, input int ns);
    bit freed [4];
    bit pre [4];
    e_ack[i] = p_req; e_gnt[i] = '0; e_we[i] = '0; e_to[i] = '0;
    for (int s = 0; s < 4; s++) begin
      pre[s] = (lk[i][s] != 0);
      freed[s] = 1'b0;
    end
    for (int c = 0; c < NC; c++) begin
      int sid;
      sid = int'(p_id[c*2 +: 2]);
      if (p_req[c] && !p_op[c] && sid < ns && lk[i][sid] != 0 && ow[i][sid] == c) begin
        lk[i][sid] = 0; ow[i][sid] = 0; e_gnt[i][c] = 1'b1; freed[sid] = 1'b1;
      end
    end
`ifdef SEMAPHORE_TIMEOUT_EN
    for (int s = 0; s < ns; s++)
      if (lk[i][s] != 0 && cnt[i][s] == TC) begin
        lk[i][s] = 0; ow[i][s] = 0; e_to[i][s] = 1'b1; freed[s] = 1'b1;
      end
`endif
    for (int s = 0; s < ns; s++) begin
      if (lk[i][s] == 0) begin
        bit found;
        found = 1'b0;
        for (int k = 0; k < NC; k++) begin
          int c;
          c = (rr[i][s] + k) % NC;
          if (!found && p_req[c] && p_op[c] && int'(p_id[c*2 +: 2]) == s) begin
            found = 1'b1;
            lk[i][s] = 1; ow[i][s] = c; rr[i][s] = (c + 1) % NC;
            e_gnt[i][c] = 1'b1; e_we[i][s*NC + c] = 1'b1;
          end
        end
        cnt[i][s] = 0;
      end else begin
        for (int c = 0; c < NC; c++)
          if (p_req[c] && p_op[c] && int'(p_id[c*2 +: 2]) == s && ow[i][s] == c)
            e_gnt[i][c] = 1'b1;
        if (pre[s] && !freed[s]) cnt[i][s] = cnt[i][s] + 1;
      end
    end
  endtask

  task automatic pack_exp();
    logic [3:0] l0, o0;
    logic [2:0] l1, o1;
    for (int s = 0; s < 4; s++) begin
      l0[s] = (lk[0][s] != 0); o0[s] = (ow[0][s] == 1);
    end
    for (int s = 0; s < 3; s++) begin
      l1[s] = (lk[1][s] != 0); o1[s] = (ow[1][s] == 1);
    end
    exp4 = {e_ack[0], e_gnt[0], l0, o0, e_we[0], e_to[0]};
    exp3 = {e_ack[1], e_gnt[1], l1, o1, e_we[1][5:0], e_to[1][2:0]};
  endtask

  // One clock: drive inputs, take the edge, advance the model to match.
  task automatic tick(input logic r, input logic [1:0] q, input logic [1:0] o, input logic [3:0] d);
    rst = r; req = q; op = o; id = d;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset(0); model_reset(1);
      p_req = '0; p_op = '0; p_id = '0;
    end else begin
      model_step(0, 4); model_step(1, 3);
      p_req = q; p_op = o; p_id = d;
    end
    pack_exp();
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0); tick(1, 0, 0, 0); tick(0, 0, 0, 0);
    n_vec++;
    if (obs4 !== 24'h0) begin $display("FAIL reset_state4 got %h want 000000", obs4); n_bad++; end
    n_vec++;
    if (obs3 !== 19'h0) begin $display("FAIL reset_state3 got %h want 00000", obs3); n_bad++; end
  endtask

  task automatic test_reset_mid();
    tick(0, 2'b01, 2'b01, 4'b0000);
    tick(1, 0, 0, 0);
    n_vec++;
    if (ack4 !== 2'b00 || lk4 !== 4'b0000) begin
      $display("FAIL reset_mid_ack got ack=%b lk=%b want 00/0000", ack4, lk4); n_bad++;
    end
    tick(0, 0, 0, 0);
    n_vec++;
    if (obs4 !== exp4 || ack4 !== 2'b00) begin $display("FAIL reset_mid_after got %h want %h", obs4, exp4); n_bad++; end
  endtask

  task automatic test_simple();
    tick(0, 2'b01, 2'b01, 4'b0010); tick(0, 0, 0, 0);
    n_vec++;
    if (ack4 !== 2'b01 || gnt4 !== 2'b01) begin $display("FAIL simple_acq got ack=%b gnt=%b want 01/01", ack4, gnt4); n_bad++; end
    n_vec++;
    if (lk4 !== 4'b0100 || ow4 !== 4'b0000 || we4 !== 8'h10) begin
      $display("FAIL simple_state got lk=%b ow=%b we=%h want 0100/0000/10", lk4, ow4, we4); n_bad++;
    end
    tick(0, 2'b10, 2'b10, 4'b1000); tick(0, 0, 0, 0);
    n_vec++;
    if (ack4 !== 2'b10 || gnt4 !== 2'b00 || we4 !== 8'h00) begin
      $display("FAIL simple_deny got ack=%b gnt=%b we=%h want 10/00/00", ack4, gnt4, we4); n_bad++;
    end
    tick(0, 2'b01, 2'b00, 4'b0010); tick(0, 0, 0, 0);
    n_vec++;
    if (gnt4 !== 2'b01 || lk4 !== 4'b0000) begin $display("FAIL simple_rel got gnt=%b lk=%b want 01/0000", gnt4, lk4); n_bad++; end
    n_vec++;
    if (obs3 !== exp3) begin $display("FAIL simple_model3 got %h want %h", obs3, exp3); n_bad++; end
  endtask

  task automatic test_fairness();
    logic [1:0] want [3];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
    for (int r = 0; r < 3; r++) begin
      tick(0, 2'b11, 2'b11, 4'b0101); tick(0, 0, 0, 0);
      n_vec++;
      if (gnt4 !== want[r] || lk4 !== 4'b0010) begin
        $display("FAIL fair_round%0d got gnt=%b lk=%b want %b/0010", r + 1, gnt4, lk4, want[r]); n_bad++;
      end
      n_vec++;
      if (obs4 !== exp4) begin $display("FAIL fair_model%0d got %h want %h", r + 1, obs4, exp4); n_bad++; end
      tick(0, want[r], 2'b00, 4'b0101); tick(0, 0, 0, 0);
    end
  endtask

  task automatic test_simul();
    tick(0, 2'b01, 2'b01, 4'b0011); tick(0, 0, 0, 0);
    tick(0, 2'b11, 2'b10, 4'b1111); tick(0, 0, 0, 0);
    n_vec++;
    if (gnt4 !== 2'b11 || lk4[3] !== 1'b1 || ow4[3] !== 1'b1 || we4 !== 8'h80) begin
      $display("FAIL simul_rel_acq got gnt=%b lk=%b ow=%b we=%h want 11/1xxx/1xxx/80", gnt4, lk4, ow4, we4); n_bad++;
    end
    tick(0, 2'b10, 2'b00, 4'b1100); tick(0, 0, 0, 0);
    n_vec++;
    if (obs4 !== exp4 || lk4 !== 4'b0000) begin $display("FAIL simul_cleanup got %h want %h", obs4, exp4); n_bad++; end
  endtask

  task automatic test_invalid();
    tick(0, 2'b10, 2'b10, 4'b0000); tick(0, 0, 0, 0);
    tick(0, 2'b01, 2'b00, 4'b0000); tick(0, 0, 0, 0);
    n_vec++;
    if (ack4 !== 2'b01 || gnt4 !== 2'b00 || lk4 !== 4'b0001 || ow4 !== 4'b0001) begin
      $display("FAIL bad_release got ack=%b gnt=%b lk=%b ow=%b want 01/00/0001/0001", ack4, gnt4, lk4, ow4); n_bad++;
    end
    tick(0, 2'b01, 2'b01, 4'b0011); tick(0, 0, 0, 0);
    n_vec++;
    if (ack3 !== 2'b01 || gnt3 !== 2'b00 || lk3 !== 3'b001 || we3 !== 6'h00) begin
      $display("FAIL out_of_range got ack=%b gnt=%b lk=%b we=%h want 01/00/001/00", ack3, gnt3, lk3, we3); n_bad++;
    end
    tick(0, 2'b11, 2'b00, 4'b0011); tick(0, 0, 0, 0);
    n_vec++;
    if (obs4 !== exp4 || obs3 !== exp3) begin $display("FAIL invalid_cleanup got %h/%h want %h/%h", obs4, obs3, exp4, exp3); n_bad++; end
  endtask

`ifdef SEMAPHORE_TIMEOUT_EN
  task automatic test_timeout();
    tick(1, 0, 0, 0); tick(0, 0, 0, 0);
    tick(0, 2'b10, 2'b10, 4'b0000); tick(0, 0, 0, 0);
    n_vec++;
    if (gnt4 !== 2'b10 || lk4[0] !== 1'b1) begin $display("FAIL tmo_grant got gnt=%b lk=%b want 10/xxx1", gnt4, lk4); n_bad++; end
    for (int n = 1; n <= 9; n++) begin
      tick(0, 0, 0, 0);
      n_vec++;
      if (to4[0] !== (n == 9) || lk4[0] !== (n != 9)) begin
        $display("FAIL tmo_hold%0d got to=%b lk=%b want to0=%0d lk0=%0d", n, to4, lk4, n == 9, n != 9); n_bad++;
      end
    end
    tick(0, 2'b10, 2'b10, 4'b0000); tick(0, 0, 0, 0);
    for (int n = 1; n <= 7; n++) tick(0, 0, 0, 0);
    tick(0, 2'b10, 2'b00, 4'b0000); tick(0, 0, 0, 0);
    n_vec++;
    if (gnt4 !== 2'b10 || to4 !== 4'b0000 || lk4 !== 4'b0000) begin
      $display("FAIL tmo_release_wins got gnt=%b to=%b lk=%b want 10/0000/0000", gnt4, to4, lk4); n_bad++;
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      logic r;
      r = ($urandom_range(0, 99) == 0);
      tick(r, 2'($urandom), 2'($urandom), 4'($urandom));
      n_vec++;
      if (obs4 !== exp4) begin $display("FAIL rand4 cyc %0d got %h want %h", n, obs4, exp4); n_bad++; end
      n_vec++;
      if (obs3 !== exp3) begin $display("FAIL rand3 cyc %0d got %h want %h", n, obs3, exp3); n_bad++; end
    end
  endtask

  initial begin
    model_reset(0); model_reset(1); pack_exp();
    test_reset();
    test_reset_mid();
    test_simple();
    test_fairness();
    test_simul();
    test_invalid();
`ifdef SEMAPHORE_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
